sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO that succeeds the fixed 256x32 SRAM-backed FIFO.
- Independent read and write pointers over an internal register array, so a read and a write can both complete in the same cycle.
- Generic WIDTH/DEPTH, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Used as the general stream buffer between datapath stages.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 55 +++++
 rtl/sync_fifo_param.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  // Per-cycle FIFO operation after accept qualification.
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD,
    OP_RDWR
  } fifo_op_e;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer with an explicit wrap, valid for any depth.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_param: one write port, one read port.
// SYNC_FIFO_FWFT_EN selects a combinational read; otherwise the read is
// registered with one cycle of latency and holds its value between reads.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Array storage, deliberately without reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rd_en ^ reset;
  assign rd_data        = mem_q[rd_addr];
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Capture the addressed word on a read, hold it otherwise.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Read data register.
  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty levels, sticky error flags and synchronous flush.
// Optional macro: SYNC_FIFO_FWFT_EN (first-word fall-through read).
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int CNT_W   = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH)
  begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             full_w, empty_w, wr_acc, rd_acc;
  fifo_op_e         op;

  // Flags from the registered count; accepts qualified by those flags and flush.
  always_comb begin
    full_w  = (count_q == CNT_W'(DEPTH));
    empty_w = (count_q == '0);
    wr_acc  = wr_en && !full_w && !flush;
    rd_acc  = rd_en && !empty_w && !flush;
    unique case ({wr_acc, rd_acc})
      2'b10:   op = OP_WR;
      2'b01:   op = OP_RD;
      2'b11:   op = OP_RDWR;
      default: op = OP_IDLE;
    endcase
  end

  // Pointer, occupancy and sticky error next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en && full_w)  overflow_d  = 1'b1;
      if (rd_en && empty_w) underflow_d = 1'b1;
      if (wr_acc) wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), DEPTH));
      if (rd_acc) rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), DEPTH));
      unique case (op)
        OP_WR:   count_d = count_q + CNT_W'(1);
        OP_RD:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = !empty_w;
`else
  logic rd_valid_q, rd_valid_d;

  // A popped word is presented exactly on the edge that accepted the read.
  always_comb begin
    rd_valid_d = rd_acc;
  end

  // Read-valid register.
  always_ff @(posedge clock) begin
    if (reset) rd_valid_q <= 1'b0;
    else       rd_valid_q <= rd_valid_d;
  end

  assign rd_valid = rd_valid_q;
`endif

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a 256-deep and a 5-deep instance are
// driven with directed and random traffic and compared against a list model.
module tb_sync_fifo_param;

  typedef logic [31:0] word_t;
  typedef struct {
    int unsigned k;
    word_t       d;
  } exp_t;

  localparam int unsigned N   = 2;
  localparam int unsigned D0  = 256;
  localparam int unsigned D1  = 5;
  localparam int unsigned AF0 = 252;
  localparam int unsigned AE0 = 4;
  localparam int unsigned AF1 = 3;
  localparam int unsigned AE1 = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush    [N];
  logic       wr_en    [N];
  word_t      wr_data  [N];
  logic       rd_en    [N];
  word_t      rd_data  [N];
  logic       rd_valid [N];
  logic       full     [N];
  logic       empty    [N];
  logic       afull    [N];
  logic       aempty   [N];
  logic       ovf      [N];
  logic       udf      [N];
  logic [8:0] count0;
  logic [2:0] count1;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        mon_en = 1'b0;

  // Reference model: each instance is a circular list of words plus flags.
  word_t       mbuf  [N][256];
  int unsigned mhead [N];
  int unsigned mcnt  [N];
  logic        movf  [N];
  logic        mudf  [N];
  logic        mvalid[N];
  word_t       mhold [N];
  exp_t        sb[$];

  always #5 clock = ~clock;

  sync_fifo_param #(.WIDTH(32), .DEPTH(D0), .AF_LEVEL(AF0), .AE_LEVEL(AE0)) u_big (
    .clock(clock), .reset(reset), .flush(flush[0]),
    .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_en(rd_en[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(afull[0]), .almost_empty(aempty[0]), .count(count0),
    .overflow(ovf[0]), .underflow(udf[0])
  );

  sync_fifo_param #(.WIDTH(32), .DEPTH(D1), .AF_LEVEL(AF1), .AE_LEVEL(AE1)) u_small (
    .clock(clock), .reset(reset), .flush(flush[1]),
    .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_en(rd_en[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(afull[1]), .almost_empty(aempty[1]), .count(count1),
    .overflow(ovf[1]), .underflow(udf[1])
  );

  function automatic int unsigned depth_of(input int unsigned k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int unsigned af_of(input int unsigned k);
    return (k == 0) ? AF0 : AF1;
  endfunction

  function automatic int unsigned ae_of(input int unsigned k);
    return (k == 0) ? AE0 : AE1;
  endfunction

  task automatic chk(input string nm, input int unsigned k, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Apply one clock edge of the FIFO rules to the model of instance k.
  task automatic model_step(input int unsigned k, input logic r, input logic f,
                            input logic w, input logic rd, input word_t d);
    int unsigned dep;
    bit          was_full, was_empty;
    dep = depth_of(k);
    if (r) begin
      mcnt[k] = 0; mhead[k] = 0; movf[k] = 0; mudf[k] = 0; mvalid[k] = 0; mhold[k] = '0;
    end else if (f) begin
      mcnt[k] = 0; mvalid[k] = 0;
    end else begin
      was_full  = (mcnt[k] == dep);
      was_empty = (mcnt[k] == 0);
      if (w && was_full)   movf[k] = 1;
      if (rd && was_empty) mudf[k] = 1;
      mvalid[k] = 0;
      if (rd && !was_empty) begin
        sb.push_back('{k, mbuf[k][mhead[k]]});
        mhold[k]  = mbuf[k][mhead[k]];
        mhead[k]  = (mhead[k] + 1) % dep;
        mcnt[k]   = mcnt[k] - 1;
        mvalid[k] = 1;
      end
      if (w && !was_full) begin
        mbuf[k][(mhead[k] + mcnt[k]) % dep] = d;
        mcnt[k] = mcnt[k] + 1;
      end
    end
  endtask

  // One clock cycle: capture inputs, take the edge, advance the model.
  task automatic cyc();
    logic  r;
    logic  f[N], w[N], rr[N];
    word_t d[N];
    r = reset;
    for (int unsigned k = 0; k < N; k++) begin
      f[k] = flush[k]; w[k] = wr_en[k]; rr[k] = rd_en[k]; d[k] = wr_data[k];
    end
    @(posedge clock);
    for (int unsigned k = 0; k < N; k++) model_step(k, r, f[k], w[k], rr[k], d[k]);
    #1;
  endtask

  task automatic idle();
    for (int unsigned k = 0; k < N; k++) begin
      flush[k] = 0; wr_en[k] = 0; rd_en[k] = 0; wr_data[k] = $urandom;
    end
  endtask

  task automatic set_all(input logic w, input logic rd);
    for (int unsigned k = 0; k < N; k++) begin
      wr_en[k] = w; rd_en[k] = rd; wr_data[k] = $urandom;
    end
  endtask

  // Monitor: compare flags every cycle and pop the scoreboard on each read.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned c;
        exp_t        e;
        c = mcnt[k];
        chk("count",        k, (k == 0) ? 32'(count0) : 32'(count1), c);
        chk("full",         k, 32'(full[k]),   32'(c == depth_of(k)));
        chk("empty",        k, 32'(empty[k]),  32'(c == 0));
        chk("almost_full",  k, 32'(afull[k]),  32'(c >= af_of(k)));
        chk("almost_empty", k, 32'(aempty[k]), 32'(c <= ae_of(k)));
        chk("overflow",     k, 32'(ovf[k]),    32'(movf[k]));
        chk("underflow",    k, 32'(udf[k]),    32'(mudf[k]));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", k, 32'(rd_valid[k]), 32'(c != 0));
        if (c != 0) chk("rd_data", k, rd_data[k], mbuf[k][mhead[k]]);
`else
        chk("rd_valid", k, 32'(rd_valid[k]), 32'(mvalid[k]));
        if (rd_valid[k] === 1'b1) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_data[%0d] got %h expected no output at %0t", k, rd_data[k], $time);
          end else begin
            e = sb.pop_front();
            chk("rd_slot", k, e.k, k);
            chk("rd_data", k, rd_data[k], e.d);
          end
        end else begin
          chk("rd_hold", k, rd_data[k], mhold[k]);
        end
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle();
    cyc();
    mon_en = 1;
    cyc();
    reset = 0;

    // Fill with 1..256 (small instance takes 5 then overflows).
    for (int unsigned i = 0; i < D0; i++) begin
      wr_en[0] = 1; wr_data[0] = i + 1;
      wr_en[1] = 1; wr_data[1] = $urandom;
      cyc();
    end
    set_all(1, 0); cyc();
    idle(); cyc();

    // Drain, then read while empty.
    for (int unsigned i = 0; i < D0; i++) begin
      set_all(0, 1); cyc();
    end
    set_all(0, 1); cyc();
    idle(); cyc();

    // Error flags persist through flush; only reset clears them.
    flush[0] = 1; flush[1] = 1; cyc();
    idle(); cyc();
    reset = 1; cyc();
    reset = 0; cyc();

    // Simultaneous read/write at empty, then at full.
    set_all(1, 1); cyc();
    for (int unsigned i = 0; i < D0; i++) begin
      set_all(1, 0); cyc();
    end
    set_all(1, 1); cyc();
    idle(); cyc();
    reset = 1; cyc();
    reset = 0;

    // Hold occupancy at 3 while streaming across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      set_all(1, 0); cyc();
    end
    for (int i = 0; i < 300; i++) begin
      set_all(1, 1); cyc();
    end
    idle(); cyc();

    // Raise the big instance to 7 entries, flush, then try to read old data.
    for (int i = 0; i < 4; i++) begin
      set_all(1, 0); cyc();
    end
    idle(); flush[0] = 1; flush[1] = 1; wr_en[0] = 1; rd_en[1] = 1; cyc();
    idle(); set_all(0, 1); cyc();
    idle(); cyc();
    reset = 1; cyc();
    reset = 0;

    // Random traffic with alternating fill/drain bias, flushes and resets.
    for (int unsigned i = 0; i < 3000; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        bit fill_phase;
        fill_phase = ((i / 400) % 2) == 0;
        wr_en[k]   = $urandom_range(99) < (fill_phase ? 75 : 25);
        rd_en[k]   = $urandom_range(99) < (fill_phase ? 25 : 75);
        wr_data[k] = $urandom;
        flush[k]   = $urandom_range(99) == 0;
      end
      reset = $urandom_range(499) == 0;
      cyc();
    end
    reset = 0;
    idle(); cyc(); cyc();

`ifndef SYNC_FIFO_FWFT_EN
    chk("scoreboard_drained", 0, sb.size(), 0);
`endif
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
